// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory interface: funct3 encodings,
// transaction state and the natural-alignment check.
package lsu_pkg;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LD  = 3'b011;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] LWU = 3'b110;

   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} lsu_state_e;

   // Stores have no unsigned forms, and 111 is not a valid width, so both are
   // reported as misaligned so that no bus cycle is issued.
   function automatic logic is_aligned(input logic [2:0] f3, input logic we,
                                       input logic [2:0] off, input logic xlen64);
      logic ok;
      case (f3[1:0])
         2'b00:   ok = 1'b1;
         2'b01:   ok = ~off[0];
         2'b10:   ok = (off[1:0] == 2'b00);
         default: ok = xlen64 && (off == 3'b000);
      endcase
      if (we && f3[2]) ok = 1'b0;
      if (f3 == 3'b111) ok = 1'b0;
      return ok;
   endfunction

endpackage

// File: rtl/store_align.sv
// Byte-strobe generation and store-data lane placement for one access.
module store_align #(
   parameter int XLEN  = 32,
   parameter int BE_W  = XLEN / 8,
   parameter int OFF_W = $clog2(BE_W)
) (
   input  logic [2:0]       funct3_i,
   input  logic [OFF_W-1:0] off_i,
   input  logic [XLEN-1:0]  wdata_i,
   output logic [BE_W-1:0]  be_o,
   output logic [XLEN-1:0]  wdata_o
);
   import lsu_pkg::*;

   always_comb begin
      be_o = '1;
      case (funct3_i)
         LB, LBU: be_o = BE_W'(1)  << off_i;
         LH, LHU: be_o = BE_W'(3)  << off_i;
         LW, LWU: be_o = BE_W'(15) << off_i;
         default: be_o = '1;
      endcase
   end

   assign wdata_o = wdata_i << {off_i, 3'b000};

endmodule

// File: rtl/lsu_mem_if.sv
// MEM-stage load/store port: checks alignment, runs one req/gnt/rvalid bus
// transaction at a time and hands the raw load word to the extension stage.
module lsu_mem_if
   import lsu_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       mem_valid_i,
   input  logic                       mem_we_i,
   input  logic [2:0]                 funct3_i,
   input  logic [ADDR_W-1:0]          addr_i,
   input  logic [XLEN-1:0]            wdata_i,
   input  logic                       flush_i,
   output logic                       stall_o,
   output logic                       misaligned_o,
   output logic                       bus_req_o,
   output logic                       bus_we_o,
   output logic [ADDR_W-1:0]          bus_addr_o,
   output logic [XLEN/8-1:0]          bus_be_o,
   output logic [XLEN-1:0]            bus_wdata_o,
   input  logic                       bus_gnt_i,
   input  logic                       bus_rvalid_i,
   input  logic [XLEN-1:0]            bus_rdata_i,
   input  logic                       bus_err_i,
   output logic [XLEN-1:0]            rd_data_o,
   output logic [$clog2(XLEN/8)-1:0]  byte_addr_o,
   output logic [2:0]                 funct3_o,
   output logic                       load_valid_o,
   output logic                       bus_fault_o
);
   localparam int BE_W  = XLEN / 8;
   localparam int OFF_W = $clog2(BE_W);

   lsu_state_e        state_q, state_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [BE_W-1:0]   be_q, be_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic [XLEN-1:0]   rdata_q, rdata_d;
   logic [OFF_W-1:0]  off_q, off_d;
   logic [2:0]        f3_q, f3_d;
   logic              err_q, err_d;
   logic              drop_q, drop_d;

   logic [BE_W-1:0]   sa_be;
   logic [XLEN-1:0]   sa_wdata;
   logic              aligned;

   store_align #(.XLEN(XLEN)) u_store_align (
      .funct3_i (funct3_i),
      .off_i    (addr_i[OFF_W-1:0]),
      .wdata_i  (wdata_i),
      .be_o     (sa_be),
      .wdata_o  (sa_wdata)
   );

   assign aligned = is_aligned(funct3_i, mem_we_i, addr_i[2:0], XLEN == 64);

   always_comb begin
      state_d      = state_q;
      req_d        = req_q;
      we_d         = we_q;
      addr_d       = addr_q;
      be_d         = be_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      off_d        = off_q;
      f3_d         = f3_q;
      err_d        = err_q;
      drop_d       = drop_q;
      stall_o      = 1'b0;
      misaligned_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_valid_i && !flush_i) begin
               if (aligned) begin
                  stall_o = 1'b1;
                  req_d   = 1'b1;
                  we_d    = mem_we_i;
                  addr_d  = {addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                  be_d    = sa_be;
                  wdata_d = sa_wdata;
                  off_d   = addr_i[OFF_W-1:0];
                  f3_d    = funct3_i;
                  err_d   = 1'b0;
                  drop_d  = 1'b0;
                  state_d = REQ;
               end else begin
                  misaligned_o = 1'b1;
               end
            end
         end
         REQ: begin
            stall_o = 1'b1;
            // Once granted the bus owns the access, so a same-cycle flush can
            // only suppress the load result, not the transaction itself.
            if (bus_gnt_i) begin
               req_d = 1'b0;
               if (we_q) begin
                  err_d   = bus_err_i;
                  state_d = DONE;
               end else begin
                  drop_d  = flush_i;
                  state_d = RESP;
               end
            end else if (flush_i) begin
               req_d   = 1'b0;
               state_d = IDLE;
            end
         end
         RESP: begin
            stall_o = 1'b1;
            if (flush_i) drop_d = 1'b1;
            if (bus_rvalid_i) begin
               rdata_d = bus_rdata_i;
               err_d   = bus_err_i;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         off_q   <= '0;
         f3_q    <= '0;
         err_q   <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         off_q   <= off_d;
         f3_q    <= f3_d;
         err_q   <= err_d;
         drop_q  <= drop_d;
      end
   end

   assign bus_req_o    = req_q;
   assign bus_we_o     = we_q;
   assign bus_addr_o   = addr_q;
   assign bus_be_o     = be_q;
   assign bus_wdata_o  = wdata_q;
   assign rd_data_o    = rdata_q;
   assign byte_addr_o  = off_q;
   assign funct3_o     = f3_q;
   assign load_valid_o = (state_q == DONE) && !we_q && !drop_q;
   assign bus_fault_o  = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed bench for lsu_mem_if: a 32-bit instance checked step by step with a
// load-result scoreboard, plus a 64-bit instance for the doubleword path.
module tb_lsu_mem_if;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_valid, mem_we, flush, gnt, rvalid, err;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata, rdata;
   logic [63:0] wdata64, rdata64;

   logic        stall, misal, req, we_o, lvalid, fault;
   logic [31:0] baddr, bwdata, rd_data;
   logic [3:0]  be;
   logic [1:0]  boff;
   logic [2:0]  f3_o;

   logic        stall6, misal6, req6, we6, lvalid6, fault6;
   logic [31:0] baddr6;
   logic [63:0] bwdata6, rd_data6;
   logic [7:0]  be6;
   logic [2:0]  boff6, f3_o6;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  off;
      logic [2:0]  f3;
   } exp_t;
   exp_t sb_q[$];

   assign wdata64 = {32'h0, wdata};
   assign rdata64 = {32'h0, rdata};

   always #5 clk = ~clk;

   lsu_mem_if #(.XLEN(32), .ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .mem_valid_i(mem_valid), .mem_we_i(mem_we),
      .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata), .flush_i(flush),
      .stall_o(stall), .misaligned_o(misal), .bus_req_o(req), .bus_we_o(we_o),
      .bus_addr_o(baddr), .bus_be_o(be), .bus_wdata_o(bwdata), .bus_gnt_i(gnt),
      .bus_rvalid_i(rvalid), .bus_rdata_i(rdata), .bus_err_i(err),
      .rd_data_o(rd_data), .byte_addr_o(boff), .funct3_o(f3_o),
      .load_valid_o(lvalid), .bus_fault_o(fault)
   );

   lsu_mem_if #(.XLEN(64), .ADDR_W(32)) dut64 (
      .clk(clk), .rst_n(rst_n), .mem_valid_i(mem_valid), .mem_we_i(mem_we),
      .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata64), .flush_i(flush),
      .stall_o(stall6), .misaligned_o(misal6), .bus_req_o(req6), .bus_we_o(we6),
      .bus_addr_o(baddr6), .bus_be_o(be6), .bus_wdata_o(bwdata6), .bus_gnt_i(gnt),
      .bus_rvalid_i(rvalid), .bus_rdata_i(rdata64), .bus_err_i(err),
      .rd_data_o(rd_data6), .byte_addr_o(boff6), .funct3_o(f3_o6),
      .load_valid_o(lvalid6), .bus_fault_o(fault6)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   // Load results are checked against the scoreboard whenever they appear.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && lvalid === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected_load", {63'h0, lvalid}, 64'h0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("sb_rd_data", {32'h0, rd_data}, {32'h0, e.data});
            chk("sb_byte_addr", {62'h0, boff}, {62'h0, e.off});
            chk("sb_funct3", {61'h0, f3_o}, {61'h0, e.f3});
         end
      end
   end

   task automatic run_load(input string t, input logic [2:0] f3, input logic [31:0] a,
                           input logic [3:0] exp_be, input logic [31:0] rd, input logic e);
      exp_t x;
      nxt();
      mem_valid = 1'b1; mem_we = 1'b0; funct3 = f3; addr = a;
      #1 chk({t, "_accept_stall"}, {63'h0, stall}, 64'h1);
      x.data = rd; x.off = a[1:0]; x.f3 = f3;
      sb_q.push_back(x);
      nxt();
      gnt = 1'b1;
      #1 chk({t, "_req"}, {63'h0, req}, 64'h1);
      chk({t, "_addr"}, {32'h0, baddr}, {32'h0, a[31:2], 2'b00});
      chk({t, "_be"}, {60'h0, be}, {60'h0, exp_be});
      chk({t, "_req_stall"}, {63'h0, stall}, 64'h1);
      nxt();
      gnt = 1'b0; rvalid = 1'b1; rdata = rd; err = e;
      #1 chk({t, "_resp_stall"}, {63'h0, stall}, 64'h1);
      chk({t, "_resp_req_low"}, {63'h0, req}, 64'h0);
      nxt();
      rvalid = 1'b0; err = 1'b0;
      #1 chk({t, "_done_stall"}, {63'h0, stall}, 64'h0);
      chk({t, "_done_lvalid"}, {63'h0, lvalid}, 64'h1);
      chk({t, "_done_fault"}, {63'h0, fault}, {63'h0, e});
      nxt();
      mem_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; mem_valid = 1'b0; mem_we = 1'b0; funct3 = 3'b0; addr = 32'h0;
      wdata = 32'h0; flush = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0; err = 1'b0;
      repeat (3) nxt();
      chk("rst_req", {63'h0, req}, 64'h0);
      chk("rst_we", {63'h0, we_o}, 64'h0);
      chk("rst_addr", {32'h0, baddr}, 64'h0);
      chk("rst_be", {60'h0, be}, 64'h0);
      chk("rst_wdata", {32'h0, bwdata}, 64'h0);
      chk("rst_rd_data", {32'h0, rd_data}, 64'h0);
      chk("rst_off_f3", {59'h0, boff, f3_o}, 64'h0);
      chk("rst_lvalid_fault", {62'h0, lvalid, fault}, 64'h0);
      chk("rst_stall", {63'h0, stall}, 64'h0);
      rst_n = 1'b1;

      // Basic word load, single-cycle gnt and rvalid.
      run_load("lw", LW, 32'h1000, 4'hF, 32'hDEADBEEF, 1'b0);

      // Byte store with a slow grant: payload must hold while req waits.
      nxt();
      mem_valid = 1'b1; mem_we = 1'b1; funct3 = LB; addr = 32'h1003; wdata = 32'h0000_00A5;
      #1 chk("sb_accept_stall", {63'h0, stall}, 64'h1);
      for (int i = 0; i < 3; i++) begin
         nxt();
         #1 chk("sb_wait_req", {63'h0, req}, 64'h1);
         chk("sb_wait_be", {60'h0, be}, 64'h8);
         chk("sb_wait_wdata", {56'h0, bwdata[31:24]}, 64'hA5);
         chk("sb_wait_addr", {32'h0, baddr}, 64'h1000);
         chk("sb_wait_we", {63'h0, we_o}, 64'h1);
      end
      nxt();
      gnt = 1'b1;
      #1 chk("sb_gnt_stall", {63'h0, stall}, 64'h1);
      nxt();
      gnt = 1'b0;
      #1 chk("sb_done_stall", {63'h0, stall}, 64'h0);
      chk("sb_done_lvalid", {63'h0, lvalid}, 64'h0);
      chk("sb_done_req", {63'h0, req}, 64'h0);
      nxt();
      mem_valid = 1'b0;

      // Misaligned and illegal encodings, plus a flushed misaligned op.
      nxt();
      mem_valid = 1'b1; mem_we = 1'b0; funct3 = LH; addr = 32'h1001;
      #1 chk("mis_lh", {62'h0, misal, stall}, 64'h2);
      nxt();
      mem_we = 1'b1; funct3 = LW; addr = 32'h1002;
      #1 chk("mis_sw", {62'h0, misal, stall}, 64'h2);
      chk("mis_lh_no_req", {63'h0, req}, 64'h0);
      nxt();
      funct3 = LBU; addr = 32'h1000;
      #1 chk("mis_store_f3_100", {62'h0, misal, stall}, 64'h2);
      chk("mis_sw_no_req", {63'h0, req}, 64'h0);
      nxt();
      flush = 1'b1; funct3 = LH; addr = 32'h1001;
      #1 chk("mis_flushed", {62'h0, misal, stall}, 64'h0);
      nxt();
      flush = 1'b0; mem_valid = 1'b0;
      #1 chk("mis_end_no_req", {63'h0, req}, 64'h0);

      // Flush while waiting for grant.
      nxt();
      mem_valid = 1'b1; mem_we = 1'b0; funct3 = LW; addr = 32'h2000;
      nxt();
      flush = 1'b1; mem_valid = 1'b0;
      #1 chk("fl_req_before", {63'h0, req}, 64'h1);
      nxt();
      flush = 1'b0;
      #1 chk("fl_req_dropped", {63'h0, req}, 64'h0);
      chk("fl_req_stall", {63'h0, stall}, 64'h0);

      // Flush while waiting for the response: response still consumed.
      nxt();
      mem_valid = 1'b1; funct3 = LW; addr = 32'h2004;
      #1 chk("flr_accept_from_idle", {63'h0, stall}, 64'h1);
      nxt();
      gnt = 1'b1;
      nxt();
      gnt = 1'b0; flush = 1'b1; mem_valid = 1'b0;
      nxt();
      flush = 1'b0;
      #1 chk("flr_still_waiting", {63'h0, stall}, 64'h1);
      rvalid = 1'b1; rdata = 32'h1234_5678;
      nxt();
      rvalid = 1'b0;
      #1 chk("flr_no_lvalid", {63'h0, lvalid}, 64'h0);
      chk("flr_stall", {63'h0, stall}, 64'h0);
      chk("flr_rd_data", {32'h0, rd_data}, 64'h1234_5678);

      // Reset in RESP, then a stale rvalid.
      nxt();
      mem_valid = 1'b1; funct3 = LHU; addr = 32'h3002;
      nxt();
      gnt = 1'b1;
      nxt();
      gnt = 1'b0; rst_n = 1'b0;
      nxt();
      rst_n = 1'b1; mem_valid = 1'b0; rvalid = 1'b1; rdata = 32'hCAFE_F00D;
      #1 chk("rr_req", {63'h0, req}, 64'h0);
      chk("rr_addr_be", {28'h0, baddr, be}, 64'h0);
      chk("rr_off_f3", {59'h0, boff, f3_o}, 64'h0);
      chk("rr_stall", {63'h0, stall}, 64'h0);
      nxt();
      rvalid = 1'b0;
      #1 chk("rr_rd_data", {32'h0, rd_data}, 64'h0);
      chk("rr_lvalid_fault", {62'h0, lvalid, fault}, 64'h0);

      // Load bus error, and a byte load at a non-zero offset.
      run_load("lw_err", LW, 32'h4008, 4'hF, 32'h55AA_55AA, 1'b1);
      run_load("lbu", LBU, 32'h4003, 4'h8, 32'h1122_3344, 1'b0);

      // Halfword store that faults on grant.
      nxt();
      mem_valid = 1'b1; mem_we = 1'b1; funct3 = LH; addr = 32'h5002; wdata = 32'h0000_BEEF;
      nxt();
      gnt = 1'b1; err = 1'b1;
      #1 chk("sh_be", {60'h0, be}, 64'hC);
      chk("sh_wdata", {48'h0, bwdata[31:16]}, 64'hBEEF);
      nxt();
      gnt = 1'b0; err = 1'b0;
      #1 chk("sh_fault", {63'h0, fault}, 64'h1);
      chk("sh_lvalid", {63'h0, lvalid}, 64'h0);
      nxt();
      mem_valid = 1'b0;

      // Doubleword: illegal at XLEN=32, full strobes at XLEN=64.
      nxt();
      mem_valid = 1'b1; mem_we = 1'b0; funct3 = LD; addr = 32'h0000_0008;
      #1 chk("ld32_misaligned", {63'h0, misal}, 64'h1);
      chk("ld64_accept", {62'h0, misal6, stall6}, 64'h1);
      nxt();
      mem_valid = 1'b0; gnt = 1'b1;
      #1 chk("ld64_be", {56'h0, be6}, 64'hFF);
      chk("ld64_addr", {32'h0, baddr6}, 64'h8);
      chk("ld32_no_req", {63'h0, req}, 64'h0);
      nxt();
      gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0BAD_F00D;
      nxt();
      rvalid = 1'b0;
      #1 chk("ld64_lvalid", {63'h0, lvalid6}, 64'h1);
      chk("ld64_rd_data", rd_data6, 64'h0BAD_F00D);

      nxt();
      chk("sb_empty", 64'(sb_q.size()), 64'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
